// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prioritised stall vector, branch redirect with
// deferral behind downstream stalls, and saturating stall/flush counters.
module pipe_ctrl #(
  parameter int CNT_W  = 32,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              branch_flag_i,
  input  logic [31:0]       branch_target_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [FCNT_W-1:0] flush_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       hold_pc_q, hold_pc_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [FCNT_W-1:0] flush_cnt_q;
  logic              downstream;

  assign downstream = stallreq_ex | stallreq_mem;

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    hold_pc_d = hold_pc_q;
    flush_o   = 1'b0;
    new_pc_o  = 32'h0;
    stall_o   = 6'b000000;

    unique case (state_q)
      IDLE: begin
        if (branch_flag_i) begin
          if (downstream) begin
            state_d   = HOLD;
            hold_pc_d = branch_target_i;
          end else begin
            flush_o  = 1'b1;
            new_pc_o = branch_target_i;
          end
        end
      end
      HOLD: begin
        // A stalled branch re-presents itself, so new branch inputs are ignored here.
        if (!downstream) begin
          flush_o  = 1'b1;
          new_pc_o = hold_pc_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Upstream stalls are squashed by a flush; downstream ones never coexist with it.
    if (stallreq_mem)                 stall_o = 6'b011111;
    else if (stallreq_ex)             stall_o = 6'b001111;
    else if (stallreq_id && !flush_o) stall_o = 6'b000111;
    else if (stallreq_if && !flush_o) stall_o = 6'b000011;

    if (!rst) begin
      flush_o  = 1'b0;
      new_pc_o = 32'h0;
      stall_o  = 6'b000000;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_pc_q   <= 32'h0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_pc_q <= hold_pc_d;
      if (stall_o[0] && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_o && (flush_cnt_q != '1))    flush_cnt_q <= flush_cnt_q + FCNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a default-width instance and a narrow
// instance (4-bit stall counter, 2-bit flush counter) share the same stimulus.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;

  logic [5:0]  stall_o, s_stall_o;
  logic        flush_o, s_flush_o;
  logic [31:0] new_pc_o, s_new_pc_o;
  logic [31:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;
  logic [3:0]  s_stall_cnt_o;
  logic [1:0]  s_flush_cnt_o;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  pipe_ctrl #(.CNT_W(4), .FCNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .stall_o(s_stall_o), .flush_o(s_flush_o), .new_pc_o(s_new_pc_o),
    .stall_cnt_o(s_stall_cnt_o), .flush_cnt_o(s_flush_cnt_o)
  );

  always #5 clk = ~clk;

  // req is {mem, ex, id, if}; stall/flush/pc are the expected outputs for that cycle.
  typedef struct {
    logic [3:0]  req;
    logic        br;
    logic [31:0] tgt;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
  } vec_t;

  vec_t sb[$];
  vec_t e;
  int   compared   = 0;
  int   mismatched = 0;

  logic [31:0] exp_scnt;
  logic [15:0] exp_fcnt;
  logic [3:0]  exp_sscnt;
  logic [1:0]  exp_sfcnt;

  function automatic vec_t mk(input logic [3:0] req, input logic br, input logic [31:0] tgt,
                              input logic [5:0] st, input logic fl, input logic [31:0] pc);
    vec_t v;
    v.req = req; v.br = br; v.tgt = tgt; v.stall = st; v.flush = fl; v.pc = pc;
    return v;
  endfunction

  task automatic clear_model();
    exp_scnt = '0; exp_fcnt = '0; exp_sscnt = '0; exp_sfcnt = '0;
  endtask

  // Advance the counter model across the edge that closes the cycle just checked.
  task automatic model_edge(input vec_t v);
    if (v.stall[0]) begin
      if (exp_scnt  != '1) exp_scnt  = exp_scnt  + 32'd1;
      if (exp_sscnt != '1) exp_sscnt = exp_sscnt + 4'd1;
    end
    if (v.flush) begin
      if (exp_fcnt  != '1) exp_fcnt  = exp_fcnt  + 16'd1;
      if (exp_sfcnt != '1) exp_sfcnt = exp_sfcnt + 2'd1;
    end
  endtask

  task automatic drive_idle();
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
    branch_flag_i   = 1'b0;
    branch_target_i = 32'h0;
  endtask

  // Drive one cycle of stimulus just after the edge, log the expectation, settle to the falling edge.
  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = v.req;
    branch_flag_i   = v.br;
    branch_target_i = v.tgt;
    sb.push_back(v);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b1111;
    branch_flag_i   = 1'b1;
    branch_target_i = 32'hABCD_0123;
    clear_model();
    #12;
    compared++;
    if ({stall_o, flush_o, new_pc_o, s_stall_o, s_flush_o, s_new_pc_o,
         stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d, want all zero",
               stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o);
    end
    drive_idle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_priority();
    vec_t v[5];
    v[0] = mk(4'b1111, 1'b0, 32'h0, 6'b011111, 1'b0, 32'h0);
    v[1] = mk(4'b0111, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0);
    v[2] = mk(4'b0011, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0);
    v[3] = mk(4'b0001, 1'b0, 32'h0, 6'b000011, 1'b0, 32'h0);
    v[4] = mk(4'b0000, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      apply(v[i]);
      e = sb.pop_front();
      compared++;
      if ({stall_o, flush_o, new_pc_o, s_stall_o, s_flush_o, s_new_pc_o,
           stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o} !==
          {e.stall, e.flush, e.pc, e.stall, e.flush, e.pc, exp_scnt, exp_fcnt, exp_sscnt, exp_sfcnt}) begin
        mismatched++;
        $display("FAIL priority[%0d]: got stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d sscnt=%0d sfcnt=%0d; want stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d sscnt=%0d sfcnt=%0d",
                 i, stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o,
                 e.stall, e.flush, e.pc, exp_scnt, exp_fcnt, exp_sscnt, exp_sfcnt);
      end
      model_edge(e);
    end
  endtask

  // Immediate redirect, then two redirects back to back.
  task automatic test_branch();
    vec_t v[4];
    v[0] = mk(4'b0000, 1'b1, 32'h0000_0104, 6'b000000, 1'b1, 32'h0000_0104);
    v[1] = mk(4'b0000, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0);
    v[2] = mk(4'b0000, 1'b1, 32'h0000_0108, 6'b000000, 1'b1, 32'h0000_0108);
    v[3] = mk(4'b0000, 1'b1, 32'h0000_010C, 6'b000000, 1'b1, 32'h0000_010C);
    for (int i = 0; i < 4; i++) begin
      apply(v[i]);
      e = sb.pop_front();
      compared++;
      if ({stall_o, flush_o, new_pc_o, s_stall_o, s_flush_o, s_new_pc_o,
           stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o} !==
          {e.stall, e.flush, e.pc, e.stall, e.flush, e.pc, exp_scnt, exp_fcnt, exp_sscnt, exp_sfcnt}) begin
        mismatched++;
        $display("FAIL branch[%0d]: got stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d sscnt=%0d sfcnt=%0d; want stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d sscnt=%0d sfcnt=%0d",
                 i, stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o,
                 e.stall, e.flush, e.pc, exp_scnt, exp_fcnt, exp_sscnt, exp_sfcnt);
      end
      model_edge(e);
    end
  endtask

  // Branch deferred behind a 3-cycle MEM stall (target garbled while held), then behind a 1-cycle EX stall.
  task automatic test_hold();
    vec_t v[9];
    v[0] = mk(4'b1000, 1'b1, 32'h0000_0200, 6'b011111, 1'b0, 32'h0);
    v[1] = mk(4'b1000, 1'b1, 32'hDEAD_BEEF, 6'b011111, 1'b0, 32'h0);
    v[2] = mk(4'b1000, 1'b1, 32'hDEAD_BEEF, 6'b011111, 1'b0, 32'h0);
    v[3] = mk(4'b0000, 1'b1, 32'hDEAD_BEEF, 6'b000000, 1'b1, 32'h0000_0200);
    v[4] = mk(4'b0000, 1'b1, 32'h0000_0300, 6'b000000, 1'b1, 32'h0000_0300);
    v[5] = mk(4'b0000, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0);
    v[6] = mk(4'b0100, 1'b1, 32'h0000_0500, 6'b001111, 1'b0, 32'h0);
    v[7] = mk(4'b0000, 1'b0, 32'h0,         6'b000000, 1'b1, 32'h0000_0500);
    v[8] = mk(4'b0000, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      apply(v[i]);
      e = sb.pop_front();
      compared++;
      if ({stall_o, flush_o, new_pc_o, s_stall_o, s_flush_o, s_new_pc_o,
           stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o} !==
          {e.stall, e.flush, e.pc, e.stall, e.flush, e.pc, exp_scnt, exp_fcnt, exp_sscnt, exp_sfcnt}) begin
        mismatched++;
        $display("FAIL hold[%0d]: got stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d sscnt=%0d sfcnt=%0d; want stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d sscnt=%0d sfcnt=%0d",
                 i, stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o,
                 e.stall, e.flush, e.pc, exp_scnt, exp_fcnt, exp_sscnt, exp_sfcnt);
      end
      model_edge(e);
    end
  endtask

  // ID/IF stalls masked by a flush from IDLE and from HOLD, but not otherwise.
  task automatic test_mask();
    vec_t v[6];
    v[0] = mk(4'b0011, 1'b1, 32'h0000_0700, 6'b000000, 1'b1, 32'h0000_0700);
    v[1] = mk(4'b0011, 1'b0, 32'h0,         6'b000111, 1'b0, 32'h0);
    v[2] = mk(4'b1000, 1'b1, 32'h0000_0600, 6'b011111, 1'b0, 32'h0);
    v[3] = mk(4'b0011, 1'b0, 32'h0,         6'b000000, 1'b1, 32'h0000_0600);
    v[4] = mk(4'b0001, 1'b0, 32'h0,         6'b000011, 1'b0, 32'h0);
    v[5] = mk(4'b0000, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      apply(v[i]);
      e = sb.pop_front();
      compared++;
      if ({stall_o, flush_o, new_pc_o, s_stall_o, s_flush_o, s_new_pc_o,
           stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o} !==
          {e.stall, e.flush, e.pc, e.stall, e.flush, e.pc, exp_scnt, exp_fcnt, exp_sscnt, exp_sfcnt}) begin
        mismatched++;
        $display("FAIL mask[%0d]: got stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d sscnt=%0d sfcnt=%0d; want stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d sscnt=%0d sfcnt=%0d",
                 i, stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o,
                 e.stall, e.flush, e.pc, exp_scnt, exp_fcnt, exp_sscnt, exp_sfcnt);
      end
      model_edge(e);
    end
  endtask

  // Reset pulled mid-HOLD discards the pending redirect.
  task automatic test_reset_in_hold();
    vec_t v[4];
    v[0] = mk(4'b1000, 1'b1, 32'h0000_0400, 6'b011111, 1'b0, 32'h0);
    v[1] = mk(4'b1000, 1'b0, 32'h0,         6'b011111, 1'b0, 32'h0);
    v[2] = mk(4'b0000, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0);
    v[3] = mk(4'b0000, 1'b0, 32'h0,         6'b000000, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        #2 rst = 1'b0;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0800;
        clear_model();
        for (int k = 0; k < 2; k++) begin
          #1;
          compared++;
          if ({stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o} !== '0) begin
            mismatched++;
            $display("FAIL reset_in_hold[%0d]: got stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d, want all zero",
                     k, stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o);
          end
          @(posedge clk);
        end
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
      end
      apply(v[i]);
      e = sb.pop_front();
      compared++;
      if ({stall_o, flush_o, new_pc_o, s_stall_o, s_flush_o, s_new_pc_o,
           stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o} !==
          {e.stall, e.flush, e.pc, e.stall, e.flush, e.pc, exp_scnt, exp_fcnt, exp_sscnt, exp_sfcnt}) begin
        mismatched++;
        $display("FAIL hold_reset[%0d]: got stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d sscnt=%0d sfcnt=%0d; want stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d sscnt=%0d sfcnt=%0d",
                 i, stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o,
                 e.stall, e.flush, e.pc, exp_scnt, exp_fcnt, exp_sscnt, exp_sfcnt);
      end
      model_edge(e);
    end
  endtask

  // Continuous stall drives the 4-bit counter to 4'hF and holds; flushes saturate the 2-bit counter.
  task automatic test_saturation();
    vec_t v[27];
    for (int i = 0; i < 20; i++) v[i] = mk(4'b0001, 1'b0, 32'h0, 6'b000011, 1'b0, 32'h0);
    for (int i = 20; i < 25; i++)
      v[i] = mk(4'b0000, 1'b1, 32'h0000_1000 + 32'(i), 6'b000000, 1'b1, 32'h0000_1000 + 32'(i));
    v[25] = mk(4'b0000, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0);
    v[26] = mk(4'b0000, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0);
    for (int i = 0; i < 27; i++) begin
      apply(v[i]);
      e = sb.pop_front();
      compared++;
      if ({stall_o, flush_o, new_pc_o, s_stall_o, s_flush_o, s_new_pc_o,
           stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o} !==
          {e.stall, e.flush, e.pc, e.stall, e.flush, e.pc, exp_scnt, exp_fcnt, exp_sscnt, exp_sfcnt}) begin
        mismatched++;
        $display("FAIL saturate[%0d]: got stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d sscnt=%0d sfcnt=%0d; want stall=%b flush=%b pc=%h scnt=%0d fcnt=%0d sscnt=%0d sfcnt=%0d",
                 i, stall_o, flush_o, new_pc_o, stall_cnt_o, flush_cnt_o, s_stall_cnt_o, s_flush_cnt_o,
                 e.stall, e.flush, e.pc, exp_scnt, exp_fcnt, exp_sscnt, exp_sfcnt);
      end
      model_edge(e);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_branch();
    test_hold();
    test_mask();
    test_reset_in_hold();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
